// File: rtl/riscv_pkg.sv
// Shared types for the RV32 five-stage pipeline.
// Fetch FSM states and instruction width constant.
package riscv_pkg;

  localparam int unsigned INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, one imem read in flight at a time,
// buffers the instruction for the Fetch->Decode register.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        stall_f_i,
  input  logic        pc_src_e_i,
  input  logic [31:0] pc_target_e_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] rd_f_o,
  output logic [31:0] pc_f_o,
  output logic [31:0] pc_plus4_f_o,
  output logic        valid_f_o
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  redir_pc_q, redir_pc_d;
  logic         redir_pend_q, redir_pend_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  target;

  assign target = {pc_target_e_i[31:2], 2'b00};

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      redir_pc_q   <= RESET_PC;
      redir_pend_q <= 1'b0;
      instr_q      <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      redir_pc_q   <= redir_pc_d;
      redir_pend_q <= redir_pend_d;
      instr_q      <= instr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    redir_pc_d   = redir_pc_q;
    redir_pend_d = redir_pend_q;
    instr_d      = instr_q;
    unique case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (pc_src_e_i) begin
          redir_pend_d = 1'b1;
          redir_pc_d   = target;
        end
        if (imem_gnt_i) state_d = WAIT;
      end
      WAIT: begin
        // A redirect arriving with rvalid still kills this response
        if (pc_src_e_i) begin
          redir_pend_d = 1'b1;
          redir_pc_d   = target;
        end
        if (imem_rvalid_i) begin
          if (redir_pend_d) begin
            pc_d         = redir_pc_d;
            redir_pend_d = 1'b0;
            state_d      = REQ;
          end else begin
            instr_d = imem_rdata_i;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (pc_src_e_i) begin
          pc_d    = target;
          state_d = REQ;
        end else if (!stall_f_i) begin
          pc_d    = pc_q + 32'(INSTR_BYTES);
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign imem_req_o   = (state_q == REQ);
  assign imem_addr_o  = pc_q;
  assign valid_f_o    = (state_q == HOLD);
  assign rd_f_o       = instr_q;
  assign pc_f_o       = pc_q;
  assign pc_plus4_f_o = pc_q + 32'(INSTR_BYTES);

endmodule
